// File: rtl/load_extend_unit_if.sv
// Request/result bus of the load extend unit: raw memory word in, aligned and
// extended result out, each side with its own valid/ready pair.
interface load_extend_unit_if #(
    parameter int DATA_W   = 32,
    parameter int OFF_W    = 2,
    parameter int ERRCNT_W = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_data;
    logic [OFF_W-1:0]    in_off;
    logic [1:0]          in_size;
    logic                in_signed;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_data;
    logic                out_err;
    logic [ERRCNT_W-1:0] err_count;

    modport master (
        output in_valid, in_data, in_off, in_size, in_signed, out_ready,
        input  in_ready, out_valid, out_data, out_err, err_count
    );

    modport slave (
        input  in_valid, in_data, in_off, in_size, in_signed, out_ready,
        output in_ready, out_valid, out_data, out_err, err_count
    );
endinterface

// File: rtl/load_extend_unit.sv
// Load alignment/extension stage: picks the addressed lane of a memory read word,
// sign/zero-extends it and queues the result in a 2-entry FIFO towards writeback.
module load_extend_unit #(
    parameter int DATA_W   = 32,
    parameter int OFF_W    = 2,
    parameter int ERRCNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    load_extend_unit_if.slave bus
);
    logic [DATA_W-1:0]   shifted;
    logic [DATA_W-1:0]   mask;
    logic [DATA_W-1:0]   res_data;
    logic                msb;
    logic                res_err;

    logic [DATA_W-1:0]   data_q [2];
    logic [DATA_W-1:0]   data_d [2];
    logic                err_q  [2];
    logic                err_d  [2];
    logic                rd_ptr_q, rd_ptr_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic [1:0]          count_q, count_d;
    logic [ERRCNT_W-1:0] err_count_q, err_count_d;
    logic                in_ready;
    logic                out_valid;
    logic                push;
    logic                pop;

    // Shift the addressed byte down to bit 0, then mask to the access width and
    // fill the upper bits with the field MSB when sign extension is requested.
    always_comb begin
        shifted = bus.in_data >> {bus.in_off, 3'b000};
        mask    = '1;
        msb     = 1'b0;
        res_err = 1'b0;
        case (bus.in_size)
            2'b00: begin
                mask = {{(DATA_W-8){1'b0}}, 8'hFF};
                msb  = shifted[7];
            end
            2'b01: begin
                mask    = {{(DATA_W-16){1'b0}}, 16'hFFFF};
                msb     = shifted[15];
                res_err = bus.in_off[0];
            end
            2'b10: begin
                mask    = {DATA_W{1'b1}} >> (DATA_W - 32);
                msb     = shifted[31];
                res_err = (bus.in_off[1:0] != 2'b00);
            end
            default: begin
                mask    = '1;
                msb     = 1'b0;
                res_err = (bus.in_off != '0);
            end
        endcase
        res_data = shifted & mask;
        if (bus.in_signed && msb) begin
            res_data = res_data | ~mask;
        end
        if (res_err) begin
            res_data = '0;
        end
    end

    // in_ready depends only on registered occupancy, so a full FIFO refuses a
    // push even in a cycle where the head is being popped.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = bus.in_valid & in_ready;
    assign pop       = out_valid & bus.out_ready;

    always_comb begin
        data_d      = data_q;
        err_d       = err_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        err_count_d = err_count_q;
        if (push) begin
            data_d[wr_ptr_q] = res_data;
            err_d[wr_ptr_q]  = res_err;
            wr_ptr_d         = ~wr_ptr_q;
            if (res_err && (err_count_q != '1)) begin
                err_count_d = err_count_q + ERRCNT_W'(1);
            end
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q      <= '{default: '0};
            err_q       <= '{default: 1'b0};
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            err_count_q <= '0;
        end else begin
            data_q      <= data_d;
            err_q       <= err_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = data_q[rd_ptr_q];
    assign bus.out_err   = err_q[rd_ptr_q];
    assign bus.err_count = err_count_q;
endmodule
